// File: rtl/ball_pkg.sv
// Shared types and default widths for the ball motion engine.
//   round_e : round FSM encoding driven on round_state
//   zone_e  : paddle zone classification returned by paddle_zone
//   XW/YW/SW: port widths for the default screen geometry
package ball_pkg;

    localparam int unsigned DEF_X_MAX     = 640;
    localparam int unsigned DEF_Y_MAX     = 480;
    localparam int unsigned DEF_MAX_SPEED = 15;

    localparam int unsigned XW = $clog2(DEF_X_MAX) + 1;
    localparam int unsigned YW = $clog2(DEF_Y_MAX) + 1;
    localparam int unsigned SW = $clog2(DEF_MAX_SPEED) + 1;

    typedef enum logic [1:0] {
        RS_SERVE  = 2'd0,
        RS_PLAY   = 2'd1,
        RS_SCORED = 2'd2
    } round_e;

    typedef enum logic [1:0] {
        ZONE_TOP    = 2'd0,
        ZONE_CENTRE = 2'd1,
        ZONE_BOTTOM = 2'd2
    } zone_e;

endpackage

// File: rtl/ball_motion_engine_paddle_zone.sv
// Combinational paddle hit test and deflection zone classification.
//   ball_y   : ball top y (pre-move)
//   paddle_y : paddle top y
//   hit_c    : ball vertically overlaps the paddle
//   zone_c   : which third of the paddle the ball centre falls in
module paddle_zone
    import ball_pkg::*;
#(
    parameter int unsigned YN       = 10,
    parameter int unsigned BOX      = 4,
    parameter int unsigned PADDLE_H = 15
) (
    input  logic [YN-1:0] ball_y,
    input  logic [YN-1:0] paddle_y,
    output logic          hit_c,
    output zone_e         zone_c
);

    // Two spare bits: one for the sum, one for the sign of d.
    localparam int unsigned DW = YN + 2;

    logic [DW-1:0]        by_e;
    logic [DW-1:0]        py_e;
    logic signed [DW-1:0] d;

    always_comb begin
        by_e  = DW'(ball_y);
        py_e  = DW'(paddle_y);
        hit_c = ((by_e + DW'(BOX)) > py_e) && (by_e < (py_e + DW'(PADDLE_H)));
        // Ball centre relative to paddle top; negative when the centre is above it.
        d     = $signed(by_e + DW'(BOX / 2) - py_e);
        if (d < $signed(DW'(PADDLE_H / 3))) begin
            zone_c = ZONE_TOP;
        end else if (d >= $signed(DW'((2 * PADDLE_H) / 3))) begin
            zone_c = ZONE_BOTTOM;
        end else begin
            zone_c = ZONE_CENTRE;
        end
    end

endmodule

// File: rtl/ball_motion_engine.sv
// Ball direction control, position physics and round FSM (serve/play/scored).
//   clk, resetn           : clock, async active-low reset
//   enable                : 0 freezes all state
//   frame_tick, new_round : frame strobe, round restart pulse
//   left/right_paddle_y   : paddle top y positions
//   ball_x/y, old_x/y     : current and previous ball top-left
//   x_dir/y_dir, x/y_speed: motion state (1 = right/down)
//   round_state           : 0 SERVE, 1 PLAY, 2 SCORED
//   moved, lhs/rhs_scored, paddle_hit, wall_hit : one-cycle event pulses
module ball_motion_engine
    import ball_pkg::*;
#(
    parameter int unsigned X_MAX         = 640,
    parameter int unsigned Y_MIN         = 20,
    parameter int unsigned Y_MAX         = 480,
    parameter int unsigned BOX           = 4,
    parameter int unsigned PADDLE_X      = 4,
    parameter int unsigned PADDLE_OFFSET = 2,
    parameter int unsigned PADDLE_H      = 15,
    parameter int unsigned BASE_SPEED    = 1,
    parameter int unsigned MAX_SPEED     = 15,
    parameter int unsigned ACCEL_FRAMES  = 30,
    parameter int unsigned SERVE_FRAMES  = 30
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       frame_tick,
    input  logic                       new_round,
    input  logic [$clog2(Y_MAX):0]     left_paddle_y,
    input  logic [$clog2(Y_MAX):0]     right_paddle_y,
    output logic [$clog2(X_MAX):0]     ball_x,
    output logic [$clog2(Y_MAX):0]     ball_y,
    output logic [$clog2(X_MAX):0]     old_x,
    output logic [$clog2(Y_MAX):0]     old_y,
    output logic                       x_dir,
    output logic                       y_dir,
    output logic [$clog2(MAX_SPEED):0] x_speed,
    output logic [$clog2(MAX_SPEED):0] y_speed,
    output logic [1:0]                 round_state,
    output logic                       moved,
    output logic                       lhs_scored,
    output logic                       rhs_scored,
    output logic                       paddle_hit,
    output logic                       wall_hit
);

    localparam int unsigned XN     = $clog2(X_MAX) + 1;
    localparam int unsigned YN     = $clog2(Y_MAX) + 1;
    localparam int unsigned SN     = $clog2(MAX_SPEED) + 1;
    localparam int unsigned XE     = XN + 1;
    localparam int unsigned YE     = YN + 1;
    localparam int unsigned SCW    = $clog2(SERVE_FRAMES + 1);
    localparam int unsigned ACW    = $clog2(ACCEL_FRAMES + 1);
    localparam int unsigned X_LLIM = PADDLE_X + PADDLE_OFFSET;
    localparam int unsigned X_RLIM = X_MAX - PADDLE_OFFSET - PADDLE_X - BOX;
    localparam int unsigned Y_BOT  = Y_MAX - BOX;
    localparam int unsigned X_CTR  = X_MAX / 2;
    localparam int unsigned Y_CTR  = Y_MAX / 2;

    logic [XN-1:0]  ball_x_q, ball_x_d, old_x_q, old_x_d;
    logic [YN-1:0]  ball_y_q, ball_y_d, old_y_q, old_y_d;
    logic           x_dir_q, x_dir_d, y_dir_q, y_dir_d;
    logic [SN-1:0]  x_speed_q, x_speed_d, y_speed_q, y_speed_d;
    round_e         state_q, state_d;
    logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
    logic [ACW-1:0] accel_cnt_q, accel_cnt_d;
    logic           moved_q, moved_d;
    logic           lhs_scored_q, lhs_scored_d;
    logic           rhs_scored_q, rhs_scored_d;
    logic           paddle_hit_q, paddle_hit_d;
    logic           wall_hit_q, wall_hit_d;

    logic [XE-1:0]  x_ext, x_spd, x_fwd;
    logic [XN-1:0]  x_back;
    logic [YE-1:0]  y_ext, y_spd, y_fwd;
    logic [YN-1:0]  y_back;
    logic           at_edge;
    logic           hit_l, hit_r, side_hit;
    zone_e          zone_l, zone_r, side_zone;

    paddle_zone #(.YN(YN), .BOX(BOX), .PADDLE_H(PADDLE_H)) u_zone_l (
        .ball_y   (ball_y_q),
        .paddle_y (left_paddle_y),
        .hit_c    (hit_l),
        .zone_c   (zone_l)
    );

    paddle_zone #(.YN(YN), .BOX(BOX), .PADDLE_H(PADDLE_H)) u_zone_r (
        .ball_y   (ball_y_q),
        .paddle_y (right_paddle_y),
        .hit_c    (hit_r),
        .zone_c   (zone_r)
    );

    // Next-state: round FSM, motion, collisions and acceleration.
    always_comb begin
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        x_dir_d      = x_dir_q;
        y_dir_d      = y_dir_q;
        x_speed_d    = x_speed_q;
        y_speed_d    = y_speed_q;
        state_d      = state_q;
        serve_cnt_d  = serve_cnt_q;
        accel_cnt_d  = accel_cnt_q;
        moved_d      = 1'b0;
        lhs_scored_d = 1'b0;
        rhs_scored_d = 1'b0;
        paddle_hit_d = 1'b0;
        wall_hit_d   = 1'b0;

        // Edge tests run one bit wider so a step past a limit never wraps.
        x_ext  = {1'b0, ball_x_q};
        x_spd  = XE'(x_speed_q);
        x_fwd  = x_ext + x_spd;
        x_back = ball_x_q - XN'(x_speed_q);
        y_ext  = {1'b0, ball_y_q};
        y_spd  = YE'(y_speed_q);
        y_fwd  = y_ext + y_spd;
        y_back = ball_y_q - YN'(y_speed_q);

        at_edge   = x_dir_q ? (x_fwd > XE'(X_RLIM)) : (x_ext < (XE'(X_LLIM) + x_spd));
        side_hit  = x_dir_q ? hit_r : hit_l;
        side_zone = x_dir_q ? zone_r : zone_l;

        if (enable) begin
            if (new_round) begin
                // Centre jump is a position update so the renderer can erase old.
                old_x_d     = ball_x_q;
                old_y_d     = ball_y_q;
                ball_x_d    = XN'(X_CTR);
                ball_y_d    = YN'(Y_CTR);
                x_speed_d   = SN'(BASE_SPEED);
                y_speed_d   = SN'(BASE_SPEED);
                serve_cnt_d = '0;
                accel_cnt_d = '0;
                state_d     = RS_SERVE;
                moved_d     = 1'b1;
            end else if (frame_tick) begin
                case (state_q)
                    RS_SERVE: begin
                        if (serve_cnt_q == SCW'(SERVE_FRAMES - 1)) begin
                            serve_cnt_d = '0;
                            state_d     = RS_PLAY;
                        end else begin
                            serve_cnt_d = serve_cnt_q + SCW'(1);
                        end
                    end
                    RS_PLAY: begin
                        old_x_d = ball_x_q;
                        old_y_d = ball_y_q;
                        moved_d = 1'b1;

                        if (y_dir_q) begin
                            if (y_fwd > YE'(Y_BOT)) begin
                                ball_y_d   = YN'(Y_BOT);
                                y_dir_d    = 1'b0;
                                wall_hit_d = 1'b1;
                            end else begin
                                ball_y_d = YN'(y_fwd);
                            end
                        end else begin
                            if (y_ext < (YE'(Y_MIN) + y_spd)) begin
                                ball_y_d   = YN'(Y_MIN);
                                y_dir_d    = 1'b1;
                                wall_hit_d = 1'b1;
                            end else begin
                                ball_y_d = y_back;
                            end
                        end

                        if (!at_edge) begin
                            ball_x_d = x_dir_q ? XN'(x_fwd) : x_back;
                        end else begin
                            ball_x_d = x_dir_q ? XN'(X_RLIM) : XN'(X_LLIM);
                            if (side_hit) begin
                                // Zone deflection overrides any wall result this tick.
                                x_dir_d      = ~x_dir_q;
                                paddle_hit_d = 1'b1;
                                case (side_zone)
                                    ZONE_TOP: begin
                                        y_dir_d   = 1'b0;
                                        y_speed_d = x_speed_q;
                                    end
                                    ZONE_BOTTOM: begin
                                        y_dir_d   = 1'b1;
                                        y_speed_d = x_speed_q;
                                    end
                                    default: begin
                                        y_speed_d = SN'(BASE_SPEED);
                                    end
                                endcase
                            end else begin
                                // Direction already points at the missed side; keep it for the serve.
                                state_d = RS_SCORED;
                                x_dir_d = x_dir_q;
                                if (x_dir_q) begin
                                    lhs_scored_d = 1'b1;
                                end else begin
                                    rhs_scored_d = 1'b1;
                                end
                            end
                        end

                        if (accel_cnt_q == ACW'(ACCEL_FRAMES - 1)) begin
                            accel_cnt_d = '0;
                            if (x_speed_q < SN'(MAX_SPEED)) begin
                                x_speed_d = x_speed_q + SN'(1);
                            end
                        end else begin
                            accel_cnt_d = accel_cnt_q + ACW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ball_x_q     <= XN'(X_CTR);
            ball_y_q     <= YN'(Y_CTR);
            old_x_q      <= XN'(X_CTR);
            old_y_q      <= YN'(Y_CTR);
            x_dir_q      <= 1'b1;
            y_dir_q      <= 1'b1;
            x_speed_q    <= SN'(BASE_SPEED);
            y_speed_q    <= SN'(BASE_SPEED);
            state_q      <= RS_SERVE;
            serve_cnt_q  <= '0;
            accel_cnt_q  <= '0;
            moved_q      <= 1'b0;
            lhs_scored_q <= 1'b0;
            rhs_scored_q <= 1'b0;
            paddle_hit_q <= 1'b0;
            wall_hit_q   <= 1'b0;
        end else begin
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            x_dir_q      <= x_dir_d;
            y_dir_q      <= y_dir_d;
            x_speed_q    <= x_speed_d;
            y_speed_q    <= y_speed_d;
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            accel_cnt_q  <= accel_cnt_d;
            moved_q      <= moved_d;
            lhs_scored_q <= lhs_scored_d;
            rhs_scored_q <= rhs_scored_d;
            paddle_hit_q <= paddle_hit_d;
            wall_hit_q   <= wall_hit_d;
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign old_x       = old_x_q;
    assign old_y       = old_y_q;
    assign x_dir       = x_dir_q;
    assign y_dir       = y_dir_q;
    assign x_speed     = x_speed_q;
    assign y_speed     = y_speed_q;
    assign round_state = state_q;
    assign moved       = moved_q;
    assign lhs_scored  = lhs_scored_q;
    assign rhs_scored  = rhs_scored_q;
    assign paddle_hit  = paddle_hit_q;
    assign wall_hit    = wall_hit_q;

endmodule
